// File: rtl/winv_loader_if.sv
// Stream-in / write-bus-out signal bundle for the inverse-twiddle loader.
// master = host side (drives the stream, observes the write bus), slave = loader.
interface winv_loader_if #(
    parameter int DLEN     = 32,
    parameter int HLEN     = 9,
    parameter int PE_DEPTH = 3
);
    logic [DLEN-1:0]            s_data;
    logic                       s_valid;
    logic                       s_ready;
    logic [(1<<PE_DEPTH)-1:0]   wen;
    logic [HLEN-1:0]            waddr;
    logic [DLEN-1:0]            wdata;

    modport master (
        output s_data, s_valid,
        input  s_ready, wen, waddr, wdata
    );

    modport slave (
        input  s_data, s_valid,
        output s_ready, wen, waddr, wdata
    );
endinterface

// File: rtl/winv_loader.sv
// Runtime writer for the per-PE inverse-twiddle RAMs: PE-major word stream in, one-hot write bus out.
// Optional trailing checksum beat is compiled in with `define WINV_LOADER_CHECKSUM_EN.
module winv_loader #(
    parameter int DLEN     = 32,
    parameter int HLEN     = 9,
    parameter int PE_DEPTH = 3,
    parameter int WORDS    = 66
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    winv_loader_if.slave    bus,
    output logic            busy,
    output logic            done,
    output logic            err
);
    localparam int PE_NUM = 1 << PE_DEPTH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CHK  = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

    logic [1:0]          state_reg;
    logic [HLEN-1:0]     word_cnt_reg;
    logic [PE_DEPTH-1:0] pe_cnt_reg;
    logic [PE_NUM-1:0]   wen_reg;
    logic [HLEN-1:0]     waddr_reg;
    logic [DLEN-1:0]     wdata_reg;
    logic                busy_reg;
    logic                done_reg;

    logic [PE_NUM-1:0]   pe_onehot;
    logic                s_ready_int;
    logic                accept;
    logic                last_word;
    logic                last_pe;

    genvar gi;
    generate
        for (gi = 0; gi < PE_NUM; gi++) begin : g_pe_sel
            assign pe_onehot[gi] = (pe_cnt_reg == PE_DEPTH'(gi));
        end
    endgenerate

    // s_ready is a pure state decode, so wen never depends combinationally on s_valid.
    assign s_ready_int = (state_reg == ST_LOAD) || (state_reg == ST_CHK);
    assign accept      = s_ready_int && bus.s_valid;
    assign last_word   = (word_cnt_reg == HLEN'(WORDS - 1));
    assign last_pe     = (pe_cnt_reg == PE_DEPTH'(PE_NUM - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            word_cnt_reg <= '0;
            pe_cnt_reg   <= '0;
            wen_reg      <= '0;
            waddr_reg    <= '0;
            wdata_reg    <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            wen_reg  <= '0;
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg    <= ST_LOAD;
                        word_cnt_reg <= '0;
                        pe_cnt_reg   <= '0;
                        busy_reg     <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        wen_reg   <= pe_onehot;
                        waddr_reg <= word_cnt_reg;
                        wdata_reg <= bus.s_data;
                        if (last_word) begin
                            word_cnt_reg <= '0;
                            pe_cnt_reg   <= pe_cnt_reg + 1'b1;
                            if (last_pe) begin
`ifdef WINV_LOADER_CHECKSUM_EN
                                state_reg <= ST_CHK;
`else
                                state_reg <= ST_FIN;
`endif
                            end
                        end else begin
                            word_cnt_reg <= word_cnt_reg + 1'b1;
                        end
                    end
                end
                ST_CHK: begin
                    if (accept) begin
                        state_reg <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

`ifdef WINV_LOADER_CHECKSUM_EN
    logic [DLEN-1:0] sum_reg;
    logic            err_reg;

    // Running sum covers data beats only; the CHK beat is compared, never added.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            if (state_reg == ST_IDLE && start) begin
                sum_reg <= '0;
                err_reg <= 1'b0;
            end else if (state_reg == ST_LOAD && accept) begin
                sum_reg <= sum_reg + bus.s_data;
            end else if (state_reg == ST_CHK && accept) begin
                err_reg <= (bus.s_data != sum_reg);
            end
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    assign bus.s_ready = s_ready_int;
    assign bus.wen     = wen_reg;
    assign bus.waddr   = waddr_reg;
    assign bus.wdata   = wdata_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
endmodule

// File: tb/tb_winv_loader.sv
// Directed/randomized bench for winv_loader against a beat-count reference model.
module tb_winv_loader;
    localparam int DLEN     = 32;
    localparam int HLEN     = 9;
    localparam int PE_DEPTH = 3;
    localparam int WORDS    = 66;
    localparam int PE_NUM   = 1 << PE_DEPTH;
    localparam int TOTAL    = PE_NUM * WORDS;
`ifdef WINV_LOADER_CHECKSUM_EN
    localparam int NBEATS   = TOTAL + 1;
`else
    localparam int NBEATS   = TOTAL;
`endif

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic busy, done, err;

    winv_loader_if #(.DLEN(DLEN), .HLEN(HLEN), .PE_DEPTH(PE_DEPTH)) bus ();

    winv_loader #(.DLEN(DLEN), .HLEN(HLEN), .PE_DEPTH(PE_DEPTH), .WORDS(WORDS)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: phase 0 idle, 1 loading, 2 finishing (cycle before done).
    int          m_phase = 0;
    int          beats   = 0;
    logic [31:0] msum    = '0;
    logic        m_err   = 1'b0;

    int          nwrites;
    int          ndone;
    logic [PE_NUM-1:0] log_wen  [TOTAL];
    logic [HLEN-1:0]   log_addr [TOTAL];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic v, input logic [31:0] d, input logic st);
        logic              acc;
        logic [PE_NUM-1:0] n_wen;
        logic [HLEN-1:0]   n_addr;
        logic [DLEN-1:0]   n_data;
        logic              n_done;
        bus.s_valid = v;
        bus.s_data  = d;
        start       = st;
        @(negedge clk);
        chk("s_ready", 64'(bus.s_ready), 64'(m_phase == 1));
        acc    = v && (m_phase == 1);
        n_wen  = '0;
        n_addr = '0;
        n_data = '0;
        n_done = 1'b0;
        case (m_phase)
            0: if (st) begin
                m_phase = 1; beats = 0; msum = '0; m_err = 1'b0;
            end
            1: if (acc) begin
                if (beats < TOTAL) begin
                    n_wen  = PE_NUM'(1) << (beats / WORDS);
                    n_addr = HLEN'(beats % WORDS);
                    n_data = d;
                    msum   = msum + d;
                end else begin
                    m_err = (d != msum);
                end
                beats++;
                if (beats == NBEATS) m_phase = 2;
            end
            default: begin
                m_phase = 0; n_done = 1'b1;
            end
        endcase
        @(posedge clk);
        #1;
        chk("wen", 64'(bus.wen), 64'(n_wen));
        if (n_wen != '0) begin
            chk("waddr", 64'(bus.waddr), 64'(n_addr));
            chk("wdata", 64'(bus.wdata), 64'(n_data));
        end
        chk("busy", 64'(busy), 64'(m_phase == 1 || m_phase == 2));
        chk("done", 64'(done), 64'(n_done));
        chk("err", 64'(err), 64'(m_err));
        if (bus.wen != '0) begin
            if (nwrites < TOTAL) begin
                log_wen[nwrites]  = bus.wen;
                log_addr[nwrites] = bus.waddr;
            end
            nwrites++;
        end
        if (done) ndone++;
    endtask

    task automatic do_reset();
        start = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        chk("rst_wen", 64'(bus.wen), 64'd0);
        chk("rst_waddr", 64'(bus.waddr), 64'd0);
        chk("rst_wdata", 64'(bus.wdata), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_s_ready", 64'(bus.s_ready), 64'd0);
        m_phase = 0;
        m_err   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // mode 0: data 0x1000+i continuous; 1: valid 1,0,0,1 random data;
    // 2: data i continuous; 3: random valid and data.
    task automatic run_load(input int mode, input int busy_start_at, input int abort_at, input bit bad_cks);
        bit          fin;
        bit          aborted;
        logic        v;
        logic [31:0] d;
        nwrites = 0;
        ndone   = 0;
        fin     = 1'b0;
        aborted = 1'b0;
        tick(1'b0, 32'd0, 1'b1);
        for (int cyc = 0; cyc < 5000 && !fin; cyc++) begin
            if (abort_at >= 0 && beats == abort_at) begin
                do_reset();
                aborted = 1'b1;
                break;
            end
            case (mode)
                1:       v = (cyc % 4 == 0) || (cyc % 4 == 3);
                3:       v = ($urandom_range(0, 3) != 0);
                default: v = 1'b1;
            endcase
            if (beats < TOTAL) begin
                case (mode)
                    0:       d = 32'h1000 + 32'(beats);
                    2:       d = 32'(beats);
                    default: d = $urandom;
                endcase
            end else begin
                d = bad_cks ? 32'd0 : msum;
            end
            tick(v, d, (beats == busy_start_at));
            if (ndone != 0) fin = 1'b1;
        end
        if (aborted) begin
            for (int k = 0; k < 20; k++) tick(1'b1, $urandom, 1'b0);
            chk("abort_no_done", 64'(ndone), 64'd0);
        end else begin
            chk("load_finished", 64'(fin), 64'd1);
            chk("write_count", 64'(nwrites), 64'(TOTAL));
            chk("done_count", 64'(ndone), 64'd1);
            tick(1'b0, 32'd0, 1'b0);
        end
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        #12;
        chk("init_wen", 64'(bus.wen), 64'd0);
        chk("init_busy", 64'(busy), 64'd0);
        chk("init_s_ready", 64'(bus.s_ready), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Reset mid-cycle with s_valid high, then stay idle.
        @(posedge clk);
        #1;
        bus.s_valid = 1'b1;
        do_reset();
        for (int k = 0; k < 100; k++) tick(1'b1, $urandom, 1'b0);

        // Continuous full load with PE boundary check.
        run_load(0, -1, -1, 1'b0);
        chk("pe_wrap_65_wen", 64'(log_wen[65]), 64'h01);
        chk("pe_wrap_65_addr", 64'(log_addr[65]), 64'd65);
        chk("pe_wrap_66_wen", 64'(log_wen[66]), 64'h02);
        chk("pe_wrap_66_addr", 64'(log_addr[66]), 64'd0);
        chk("full_err", 64'(err), 64'd0);

        // Back-pressure gaps.
        run_load(1, -1, -1, 1'b0);
        chk("gap_last_wen", 64'(log_wen[TOTAL-1]), 64'h80);
        chk("gap_last_addr", 64'(log_addr[TOTAL-1]), 64'd65);

        // Start while busy at beat 100, reset at beat 200, then fresh load.
        run_load(3, 100, 200, 1'b0);
        chk("abort_busy", 64'(busy), 64'd0);
        run_load(3, 100, -1, 1'b0);
        chk("restart_first_wen", 64'(log_wen[0]), 64'h01);
        chk("restart_first_addr", 64'(log_addr[0]), 64'd0);

        // Data = i; good then bad checksum (bad ignored without the feature).
        run_load(2, -1, -1, 1'b0);
        chk("cks_good_err", 64'(err), 64'd0);
        run_load(2, -1, -1, 1'b1);
`ifdef WINV_LOADER_CHECKSUM_EN
        chk("cks_bad_err", 64'(err), 64'd1);
`else
        chk("cks_bad_err", 64'(err), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
